// File: rtl/bip_reporter.sv
// -----------------------------------------------------------------------------
// bip_reporter
//
// This block sits between the BIP core and the UART transmitter. It counts
// the clock cycles the CPU spends running. When the CPU executes HALT, the
// block freezes the CPU and sends one fixed report frame through the UART
// transmitter, one byte at a time.
//
// Frame layout, with each field sent MSB byte first:
//   HEADER | cycle count (NB_CYCLES/8 bytes) | PC zero-extended to 16 bits
//   (2 bytes) | ACC (NB_DATA/8 bytes)
//
// Ports:
//   i_clock       system clock; all logic updates on the rising edge
//   i_reset       synchronous, active-high reset
//   i_halt        high while the CPU decodes a HALT instruction
//   i_acc         CPU accumulator
//   i_pc          CPU program counter
//   i_tx_done     one-cycle pulse from UART TX when the current byte is done
//   o_tx_start    one-cycle request to UART TX to send o_tx_data
//   o_tx_data     byte to transmit; stays stable until its done pulse
//   o_cpu_enable  CPU clock enable; high while the CPU runs
//   o_done        high once the whole frame has been sent and acknowledged
// -----------------------------------------------------------------------------
module bip_reporter #(
    parameter int          NB_DATA   = 16,
    parameter int          NB_ADDR   = 11,
    parameter int          NB_CYCLES = 32,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_acc,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [7:0]         o_tx_data,
    output logic               o_cpu_enable,
    output logic               o_done
);

    localparam int FRAME_BITS  = 8 + NB_CYCLES + 16 + NB_DATA;
    localparam int FRAME_BYTES = FRAME_BITS / 8;
    localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                 r_state;
    logic [NB_CYCLES-1:0]   r_count;
    logic [IDX_W-1:0]       r_index;
    logic [FRAME_BITS-1:0]  r_shift;
    logic                   r_tx_start;
    logic                   r_cpu_enable;
    logic                   r_done;

    logic [15:0]            w_pc16;
    logic                   w_count_max;

    // The size cast zero-extends the PC to the 16-bit field in the frame.
    assign w_pc16      = 16'(i_pc);
    assign w_count_max = &r_count;

    // The top byte of the shift register is always the byte being sent.
    // Every output comes straight from a register, so the outputs are glitch-free.
    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_shift[FRAME_BITS-1 -: 8];
    assign o_cpu_enable = r_cpu_enable;
    assign o_done       = r_done;

    // NOTE: state updates use non-blocking assignments so that every register
    // samples the values from before the edge. Reset is synchronous and clears
    // the snapshot as well, so an aborted frame never resumes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_RUN;
            r_count      <= '0;
            r_index      <= '0;
            r_shift      <= '0;
            r_tx_start   <= 1'b0;
            r_cpu_enable <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            // The start request is a single-cycle pulse. It is raised only on
            // the transitions into SEND.
            r_tx_start <= 1'b0;

            case (r_state)
                ST_RUN: begin
                    if (i_halt) begin
                        // The halt cycle is not counted. The snapshot takes
                        // PC and ACC from this same edge.
                        r_shift      <= {HEADER, r_count, w_pc16, i_acc};
                        r_index      <= '0;
                        r_tx_start   <= 1'b1;
                        r_cpu_enable <= 1'b0;
                        r_state      <= ST_SEND;
                    end else if (!w_count_max) begin
                        // The counter saturates instead of wrapping.
                        r_count <= r_count + NB_CYCLES'(1);
                    end
                end

                ST_SEND: begin
                    // A done pulse that arrives while the start is still
                    // high cannot belong to this byte, so it is ignored.
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (r_index == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_shift    <= r_shift << 8;
                            r_index    <= r_index + IDX_W'(1);
                            r_tx_start <= 1'b1;
                            r_state    <= ST_SEND;
                        end
                    end
                end

                ST_DONE: begin
                    // Terminal state. Only i_reset leaves it.
                end

                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_reporter.sv
// -----------------------------------------------------------------------------
// tb_bip_reporter
//
// Directed bench for bip_reporter. The bench holds two instances:
//   dut_a  default parameters, 9-byte frame
//   dut_b  NB_CYCLES = 8, 6-byte frame, used for counter saturation
// Both instances share the stimulus signals. The instance not under test is
// held in reset, and `sel` picks which instance's outputs get checked.
// -----------------------------------------------------------------------------
module tb_bip_reporter;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic        halt;
    logic [15:0] acc;
    logic [10:0] pc;
    logic        tx_done;
    logic        sel;

    logic        a_start, a_en, a_done;
    logic [7:0]  a_data;
    logic        b_start, b_en, b_done;
    logic [7:0]  b_data;

    logic        start, en, done;
    logic [7:0]  data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bip_reporter dut_a (
        .i_clock      (clk),
        .i_reset      (rst_a),
        .i_halt       (halt),
        .i_acc        (acc),
        .i_pc         (pc),
        .i_tx_done    (tx_done),
        .o_tx_start   (a_start),
        .o_tx_data    (a_data),
        .o_cpu_enable (a_en),
        .o_done       (a_done)
    );

    bip_reporter #(.NB_CYCLES(8)) dut_b (
        .i_clock      (clk),
        .i_reset      (rst_b),
        .i_halt       (halt),
        .i_acc        (acc),
        .i_pc         (pc),
        .i_tx_done    (tx_done),
        .o_tx_start   (b_start),
        .o_tx_data    (b_data),
        .o_cpu_enable (b_en),
        .o_done       (b_done)
    );

    assign start = sel ? b_start : a_start;
    assign data  = sel ? b_data  : a_data;
    assign en    = sel ? b_en    : a_en;
    assign done  = sel ? b_done  : a_done;

    typedef struct {
        int          run_cycles;  // halt-low cycles before the halt edge
        logic [15:0] acc;
        logic [10:0] pc;
        int          delay;       // done delay per byte; 0 = vary from 1 to 20
        bit          spurious;    // inject stray done/halt pulses
        bit          sel;         // 0 = dut_a, 1 = dut_b
        int          nbytes;
        logic [71:0] frame;       // expected bytes, left-aligned
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one frame on the selected instance. If abort_after is nonzero, the
    // task pulses reset for one cycle after that many done pulses.
    task automatic run_frame(input vec_t v, input bit do_reset, input int abort_after);
        sel = v.sel;
        if (do_reset) begin
            @(negedge clk);
            rst_a = 1'b1; rst_b = 1'b1; halt = 1'b0; tx_done = 1'b0;
            @(negedge clk);
            check("reset_start", 32'(start), 32'(0));
            check("reset_data",  32'(data),  32'h00);
            check("reset_en",    32'(en),    32'(1));
            check("reset_done",  32'(done),  32'(0));
        end
        if (v.sel) rst_b = 1'b0; else rst_a = 1'b0;

        // Run phase. Stray done pulses here must be ignored.
        tx_done = v.spurious;
        repeat (v.run_cycles) @(negedge clk);
        check("run_en",    32'(en),    32'(1));
        check("run_start", 32'(start), 32'(0));

        tx_done = 1'b0; halt = 1'b1; acc = v.acc; pc = v.pc;
        @(negedge clk);
        // Change the CPU signals after capture. The frame must not change.
        halt = 1'b0; acc = ~v.acc; pc = ~v.pc;

        for (int b = 0; b < v.nbytes; b++) begin
            logic [7:0] exp_b;
            int         d;
            exp_b = v.frame[71 - 8*b -: 8];
            d     = (v.delay == 0) ? ((b * 13) % 20) + 1 : v.delay;

            check($sformatf("b%0d_start", b), 32'(start), 32'(1));
            check($sformatf("b%0d_data",  b), 32'(data),  32'(exp_b));
            check($sformatf("b%0d_en",    b), 32'(en),    32'(0));
            check($sformatf("b%0d_done",  b), 32'(done),  32'(0));

            // A done pulse sampled while the start is high must be ignored.
            if (v.spurious) tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            if (v.spurious) halt = 1'b1;

            for (int k = 0; k < d; k++) begin
                check($sformatf("b%0d_wait_start", b), 32'(start), 32'(0));
                check($sformatf("b%0d_wait_data",  b), 32'(data),  32'(exp_b));
                if (k == d - 1) tx_done = 1'b1;
                @(negedge clk);
            end
            tx_done = 1'b0;
            halt    = 1'b0;

            if (abort_after == b + 1) begin
                if (v.sel) rst_b = 1'b1; else rst_a = 1'b1;
                @(negedge clk);
                check("abort_start", 32'(start), 32'(0));
                check("abort_en",    32'(en),    32'(1));
                check("abort_done",  32'(done),  32'(0));
                return;
            end
        end

        check("final_done",  32'(done),  32'(1));
        check("final_start", 32'(start), 32'(0));
        check("final_en",    32'(en),    32'(0));

        if (v.spurious) begin
            // In DONE, stray done and halt pulses must not restart anything.
            for (int k = 0; k < 4; k++) begin
                tx_done = 1'b1; halt = 1'b1;
                @(negedge clk);
                check("post_start", 32'(start), 32'(0));
                check("post_done",  32'(done),  32'(1));
            end
            tx_done = 1'b0; halt = 1'b0;
        end
    endtask

    initial begin
        vec_t v_abort;
        vec_t v_fresh;

        rst_a = 1'b1; rst_b = 1'b1; halt = 1'b0; acc = '0; pc = '0;
        tx_done = 1'b0; sel = 1'b0;

        // Nominal frame: count 10, done 5 cycles after each start.
        vecs[0] = '{10, 16'h1234, 11'h005, 5, 1'b0, 1'b0, 9, 72'hA5_0000000A_0005_1234};
        // Halt on the first cycle after reset; done delay varies from 1 to 20.
        vecs[1] = '{0, 16'hABCD, 11'h7FF, 0, 1'b0, 1'b0, 9, 72'hA5_00000000_07FF_ABCD};
        // Stray done pulses in RUN, SEND and DONE; extra halts after capture.
        vecs[2] = '{3, 16'h0F0F, 11'h123, 2, 1'b1, 1'b0, 9, 72'hA5_00000003_0123_0F0F};
        // 8-bit counter: 300 cycles saturate to FF; the frame has 6 bytes.
        vecs[3] = '{300, 16'hBEEF, 11'h7FF, 1, 1'b0, 1'b1, 6, 72'hA5_FF_07FF_BEEF_000000};

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], 1'b1, 0);
        end

        // Reset for one cycle after the 3rd done pulse. A fresh halt after
        // 7 cycles must then produce a complete new frame.
        v_abort = '{4, 16'h5555, 11'h0AA, 3, 1'b0, 1'b0, 9, 72'hA5_00000004_00AA_5555};
        v_fresh = '{7, 16'h1234, 11'h005, 2, 1'b0, 1'b0, 9, 72'hA5_00000007_0005_1234};
        run_frame(v_abort, 1'b1, 3);
        run_frame(v_fresh, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
